// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: direction codes, colours, FSM states.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN_WAIT,
        CALC,
        SCAN,
        ERASE,
        DRAW,
        DEAD
    } state_e;

    // Opposite directions differ only in bit 0.
    function automatic dir_e reverse_of(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/segment_ram.sv
// Circular body buffer: push writes at head_ptr, pop retires tail_ptr, async read.
module segment_ram #(
    parameter  int unsigned MAX_LEN = 64,
    parameter  int unsigned DW      = 12,
    localparam int unsigned PW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic [PW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [PW-1:0] head_ptr,
    output logic [PW-1:0] tail_ptr
);

    logic [DW-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[head_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because MAX_LEN is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (push) head_ptr <= head_ptr + PW'(1);
            if (pop)  tail_ptr <= tail_ptr + PW'(1);
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/snake_body_engine.sv
// Multi-segment snake: steps one cell per tick, grows on food, detects collisions,
// and streams head-draw / tail-erase pixels to the VGA adapter.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter  int unsigned GRID_W   = 40,
    parameter  int unsigned GRID_H   = 30,
    parameter  int unsigned CELL_PX  = 4,
    parameter  int unsigned MAX_LEN  = 64,
    parameter  int unsigned INIT_LEN = 3,
    parameter  int unsigned CW       = 6,
    parameter  int unsigned PXW      = 8,
    localparam int unsigned LW       = $clog2(MAX_LEN) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           tick,
    input  logic           dir_valid,
    input  logic [1:0]     dir_req,
    input  logic [CW-1:0]  food_x,
    input  logic [CW-1:0]  food_y,
    output logic           food_eaten,
    output logic [PXW-1:0] pix_x,
    output logic [PXW-1:0] pix_y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           game_over,
    output logic [LW-1:0]  length
);

    localparam int unsigned PW      = $clog2(MAX_LEN);
    localparam int unsigned DW      = 2 * CW;
    localparam int unsigned XW      = CW + 1;
    localparam int unsigned CPB     = $clog2(CELL_PX);
    localparam int unsigned OFFW    = 2 * CPB;
    localparam int unsigned INIT_X0 = GRID_W / 2 - INIT_LEN + 1;
    localparam int unsigned MID_Y   = GRID_H / 2;

    state_e          state, state_n;
    dir_e            dir, dir_n, pend_dir, pend_n, step_dir;
    logic [CW-1:0]   nx, nx_n, ny, ny_n, head_x, hx_n, head_y, hy_n;
    logic            grow, grow_n, food_hit, hit_n, wipe, wipe_n;
    logic [LW-1:0]   cnt, cnt_n, scan_len, scan_n_n, length_n;
    logic [OFFW-1:0] off, off_n;
    logic            plot_n, food_n, busy_n, go_n, begin_init;
    logic [2:0]      colour_n;
    logic [PXW-1:0]  pix_x_n, pix_y_n;
    logic [CW-1:0]   cell_x, cell_y;
    logic [XW-1:0]   nx_w, ny_w;
    logic            off_grid, on_food, grow_c, off_last;

    logic            push, pop;
    logic [DW-1:0]   push_data, rd_data;
    logic [PW-1:0]   rd_addr, head_ptr, tail_ptr;

    segment_ram #(.MAX_LEN(MAX_LEN), .DW(DW)) u_ram (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .head_ptr  (head_ptr),
        .tail_ptr  (tail_ptr)
    );

    assign step_dir  = (pend_dir == reverse_of(dir)) ? dir : pend_dir;
    assign push_data = {cell_x, cell_y};
    assign off_last  = &off;

    // Next head with one extra bit so an underflow past 0 lands out of range.
    always_comb begin
        nx_w = {1'b0, head_x};
        ny_w = {1'b0, head_y};
        case (step_dir)
            DIR_RIGHT: nx_w = {1'b0, head_x} + XW'(1);
            DIR_LEFT:  nx_w = {1'b0, head_x} - XW'(1);
            DIR_UP:    ny_w = {1'b0, head_y} - XW'(1);
            DIR_DOWN:  ny_w = {1'b0, head_y} + XW'(1);
        endcase
    end

    assign off_grid = (nx_w >= XW'(GRID_W)) || (ny_w >= XW'(GRID_H));
    assign on_food  = (nx_w[CW-1:0] == food_x) && (ny_w[CW-1:0] == food_y);
    assign grow_c   = on_food && (length < LW'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dir        <= DIR_RIGHT;
            pend_dir   <= DIR_RIGHT;
            nx         <= '0;
            ny         <= '0;
            head_x     <= '0;
            head_y     <= '0;
            grow       <= 1'b0;
            food_hit   <= 1'b0;
            wipe       <= 1'b0;
            cnt        <= '0;
            scan_len   <= '0;
            off        <= '0;
            length     <= '0;
            food_eaten <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            pend_dir   <= pend_n;
            nx         <= nx_n;
            ny         <= ny_n;
            head_x     <= hx_n;
            head_y     <= hy_n;
            grow       <= grow_n;
            food_hit   <= hit_n;
            wipe       <= wipe_n;
            cnt        <= cnt_n;
            scan_len   <= scan_n_n;
            off        <= off_n;
            length     <= length_n;
            food_eaten <= food_n;
            pix_x      <= pix_x_n;
            pix_y      <= pix_y_n;
            colour     <= colour_n;
            plot       <= plot_n;
            busy       <= busy_n;
            game_over  <= go_n;
        end
    end

    always_comb begin
        state_n    = state;
        dir_n      = dir;
        pend_n     = dir_valid ? dir_e'(dir_req) : pend_dir;
        nx_n       = nx;
        ny_n       = ny;
        hx_n       = head_x;
        hy_n       = head_y;
        grow_n     = grow;
        hit_n      = food_hit;
        wipe_n     = wipe;
        cnt_n      = cnt;
        scan_n_n   = scan_len;
        off_n      = off;
        length_n   = length;
        cell_x     = nx;
        cell_y     = ny;
        colour_n   = GREEN;
        plot_n     = 1'b0;
        food_n     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        begin_init = 1'b0;
        rd_addr    = head_ptr - PW'(1) - PW'(cnt);

        case (state)
            IDLE: begin
                if (start) begin_init = 1'b1;
            end
            INIT: begin
                cell_x = CW'(INIT_X0) + CW'(cnt);
                cell_y = CW'(MID_Y);
                plot_n = 1'b1;
                off_n  = off + OFFW'(1);
                if (off_last) begin
                    push     = 1'b1;
                    hx_n     = cell_x;
                    hy_n     = cell_y;
                    length_n = length + LW'(1);
                    cnt_n    = cnt + LW'(1);
                    if (cnt == LW'(INIT_LEN - 1)) state_n = RUN_WAIT;
                end
            end
            RUN_WAIT: begin
                if (tick) state_n = CALC;
            end
            CALC: begin
                dir_n    = step_dir;
                nx_n     = nx_w[CW-1:0];
                ny_n     = ny_w[CW-1:0];
                hit_n    = on_food;
                grow_n   = grow_c;
                cnt_n    = '0;
                off_n    = '0;
                // The tail vacates its cell on a plain move, so it is not scanned.
                scan_n_n = grow_c ? length : length - LW'(1);
                if (off_grid)              state_n = DEAD;
                else if (scan_n_n == '0)   state_n = grow_c ? DRAW : ERASE;
                else                       state_n = SCAN;
            end
            SCAN: begin
                if (rd_data == {nx, ny})                 state_n = DEAD;
                else if (cnt == scan_len - LW'(1))       state_n = grow ? DRAW : ERASE;
                else                                     cnt_n   = cnt + LW'(1);
            end
            ERASE: begin
                rd_addr  = tail_ptr;
                cell_x   = rd_data[DW-1:CW];
                cell_y   = rd_data[CW-1:0];
                colour_n = BLACK;
                plot_n   = 1'b1;
                off_n    = off + OFFW'(1);
                if (off_last) begin
                    pop = 1'b1;
                    if (!wipe) begin
                        state_n = DRAW;
                    end else begin
                        length_n = length - LW'(1);
                        if (length == LW'(1)) begin
                            wipe_n     = 1'b0;
                            begin_init = 1'b1;
                        end
                    end
                end
            end
            DRAW: begin
                plot_n = 1'b1;
                off_n  = off + OFFW'(1);
                food_n = food_hit && (off == '0);
                if (off_last) begin
                    push    = 1'b1;
                    hx_n    = nx;
                    hy_n    = ny;
                    state_n = RUN_WAIT;
                    if (grow) length_n = length + LW'(1);
                end
            end
            DEAD: begin
                if (start) begin
                    if (length == '0) begin
                        begin_init = 1'b1;
                    end else begin
                        wipe_n  = 1'b1;
                        off_n   = '0;
                        state_n = ERASE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A fresh snake always lies horizontally facing right.
        if (begin_init) begin
            state_n = INIT;
            cnt_n   = '0;
            off_n   = '0;
            dir_n   = DIR_RIGHT;
            if (!dir_valid) pend_n = DIR_RIGHT;
        end

        pix_x_n = PXW'({cell_x, off[CPB-1:0]});
        pix_y_n = PXW'({cell_y, off[OFFW-1:CPB]});
        busy_n  = !(state_n inside {IDLE, RUN_WAIT, DEAD});
        go_n    = (state_n == DEAD);
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: default build plus a MAX_LEN=4 build.
module tb_snake_body_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b, start, tick, dir_valid, sel;
    logic [1:0] dir_req;
    logic [5:0] food_x, food_y;

    logic       fe_a, plot_a, busy_a, go_a;
    logic [7:0] px_a, py_a;
    logic [2:0] col_a;
    logic [6:0] len_a;
    logic       fe_b, plot_b, busy_b, go_b;
    logic [7:0] px_b, py_b;
    logic [2:0] col_b;
    logic [2:0] len_b;

    logic       m_fe, m_plot, m_busy, m_go;
    logic [7:0] m_px, m_py;
    logic [2:0] m_col;
    logic [6:0] m_len;

    snake_body_engine u_a (
        .clk(clk), .reset(reset_a), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .food_eaten(fe_a), .pix_x(px_a), .pix_y(py_a), .colour(col_a),
        .plot(plot_a), .busy(busy_a), .game_over(go_a), .length(len_a)
    );

    snake_body_engine #(.MAX_LEN(4)) u_b (
        .clk(clk), .reset(reset_b), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .food_eaten(fe_b), .pix_x(px_b), .pix_y(py_b), .colour(col_b),
        .plot(plot_b), .busy(busy_b), .game_over(go_b), .length(len_b)
    );

    assign m_fe   = sel ? fe_b   : fe_a;
    assign m_plot = sel ? plot_b : plot_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_go   = sel ? go_b   : go_a;
    assign m_px   = sel ? px_b   : px_a;
    assign m_py   = sel ? py_b   : py_a;
    assign m_col  = sel ? col_b  : col_a;
    assign m_len  = sel ? {4'b0000, len_b} : len_a;

    int n_cmp = 0;
    int n_err = 0;
    int n_plot, n_blk, n_grn, n_food, last_k, end_k, done;
    int fb_x, fb_y, lb_x, lb_y, fg_x, fg_y, lg_x, lg_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start or tick, then gather the pixel stream until busy drops.
    task automatic run_op(input bit use_start, input bit also_start, input int inject_k, input int max_k);
        n_plot = 0; n_blk = 0; n_grn = 0; n_food = 0; last_k = 0; end_k = 0; done = 0;
        fb_x = -1; fb_y = -1; lb_x = -1; lb_y = -1;
        fg_x = -1; fg_y = -1; lg_x = -1; lg_y = -1;
        @(negedge clk);
        if (use_start) start = 1'b1;
        else begin
            tick  = 1'b1;
            start = also_start;
        end
        @(negedge clk);
        start = 1'b0;
        tick  = 1'b0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (m_plot) begin
                n_plot++;
                last_k = k;
                if (m_col == 3'b000) begin
                    if (n_blk == 0) begin fb_x = int'(m_px); fb_y = int'(m_py); end
                    lb_x = int'(m_px); lb_y = int'(m_py);
                    n_blk++;
                end else if (m_col == 3'b010) begin
                    if (n_grn == 0) begin fg_x = int'(m_px); fg_y = int'(m_py); end
                    lg_x = int'(m_px); lg_y = int'(m_py);
                    n_grn++;
                end
            end
            if (m_fe) n_food++;
            tick = (k == inject_k);
            if (!m_busy) begin
                done  = 1;
                end_k = k;
                break;
            end
        end
        tick = 1'b0;
        check("op_timeout", done, 1);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (m_plot || m_busy) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk);
        dir_valid = 1'b1;
        dir_req   = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    initial begin
        sel = 1'b0; reset_a = 1'b1; reset_b = 1'b1; start = 1'b0; tick = 1'b0;
        dir_valid = 1'b0; dir_req = 2'd0; food_x = 6'd39; food_y = 6'd29;
        repeat (3) @(negedge clk);
        check("rst_plot", 32'(m_plot), 0);
        check("rst_busy", 32'(m_busy), 0);
        check("rst_go",   32'(m_go), 0);
        check("rst_fe",   32'(m_fe), 0);
        check("rst_len",  32'(m_len), 0);
        check("rst_pix",  32'({m_px, m_py}), 0);
        check("rst_col",  32'(m_col), 0);
        reset_a = 1'b0;

        // Tick in IDLE is ignored.
        @(negedge clk); tick = 1'b1; @(negedge clk); tick = 1'b0;
        idle_check("idle_tick", 4);

        run_op(1'b1, 1'b0, 0, 200);
        check("init_plots", n_grn, 48);
        check("init_black", n_blk, 0);
        check("init_fg_x", fg_x, 72);
        check("init_fg_y", fg_y, 60);
        check("init_lg_x", lg_x, 83);
        check("init_lg_y", lg_y, 63);
        check("init_lat", last_k, 48);
        check("init_len", 32'(m_len), 3);

        // Plain move right with start also high: tick wins.
        run_op(1'b0, 1'b1, 0, 200);
        check("mv1_blk", n_blk, 16);
        check("mv1_fb_x", fb_x, 72);
        check("mv1_fb_y", fb_y, 60);
        check("mv1_lb_x", lb_x, 75);
        check("mv1_lb_y", lb_y, 63);
        check("mv1_grn", n_grn, 16);
        check("mv1_fg_x", fg_x, 84);
        check("mv1_lg_x", lg_x, 87);
        check("mv1_lat", last_k, 35);
        check("mv1_len", 32'(m_len), 3);
        check("mv1_food", n_food, 0);

        // Grow onto food at (22,15).
        food_x = 6'd22; food_y = 6'd15;
        run_op(1'b0, 1'b0, 0, 200);
        food_x = 6'd39; food_y = 6'd29;
        check("grow_blk", n_blk, 0);
        check("grow_grn", n_grn, 16);
        check("grow_fg_x", fg_x, 88);
        check("grow_food", n_food, 1);
        check("grow_lat", last_k, 20);
        check("grow_len", 32'(m_len), 4);

        // Reverse request ignored; mid-move tick dropped.
        set_dir(2'd1);
        run_op(1'b0, 1'b0, 10, 200);
        check("rev_fb_x", fb_x, 76);
        check("rev_fg_x", fg_x, 92);
        check("rev_fg_y", fg_y, 60);
        check("rev_lat", last_k, 36);
        idle_check("drop_tick", 40);

        food_x = 6'd24; food_y = 6'd15;
        run_op(1'b0, 1'b0, 0, 200);
        food_x = 6'd39; food_y = 6'd29;
        check("grow5_len", 32'(m_len), 5);
        check("grow5_lat", last_k, 21);

        set_dir(2'd2);
        run_op(1'b0, 1'b0, 0, 200);
        check("up_fb_x", fb_x, 80);
        check("up_fg_x", fg_x, 96);
        check("up_fg_y", fg_y, 56);
        check("up_lat", last_k, 37);

        set_dir(2'd1);
        run_op(1'b0, 1'b0, 0, 200);
        check("left_fb_x", fb_x, 84);
        check("left_fg_x", fg_x, 92);
        check("left_fg_y", fg_y, 56);

        set_dir(2'd3);
        run_op(1'b0, 1'b0, 0, 200);
        check("self_plots", n_plot, 0);
        check("self_end", end_k, 5);
        check("self_go", 32'(m_go), 1);
        check("self_len", 32'(m_len), 5);

        // Tick in DEAD is dropped.
        @(negedge clk); tick = 1'b1; @(negedge clk); tick = 1'b0;
        idle_check("dead_tick", 4);
        check("dead_go", 32'(m_go), 1);

        // Restart: erase all five segments tail to head, then re-init.
        run_op(1'b1, 1'b0, 0, 400);
        check("wipe_blk", n_blk, 80);
        check("wipe_fb_x", fb_x, 88);
        check("wipe_fb_y", fb_y, 60);
        check("wipe_lb_x", lb_x, 95);
        check("wipe_lb_y", lb_y, 59);
        check("wipe_grn", n_grn, 48);
        check("wipe_fg_x", fg_x, 72);
        check("wipe_lat", last_k, 128);
        check("wipe_len", 32'(m_len), 3);
        check("wipe_go", 32'(m_go), 0);

        // Wall: from a fresh reset go up, then left to x=0, then off the edge.
        reset_a = 1'b1;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        run_op(1'b1, 1'b0, 0, 200);
        check("wall_init", n_grn, 48);
        set_dir(2'd2);
        run_op(1'b0, 1'b0, 0, 200);
        check("wall_up_fb_x", fb_x, 72);
        check("wall_up_fg", fg_x * 1000 + fg_y, 80 * 1000 + 56);
        set_dir(2'd1);
        for (int i = 1; i <= 20; i++) begin
            run_op(1'b0, 1'b0, 0, 200);
            check($sformatf("walk%0d_fg", i), fg_x * 1000 + fg_y, (20 - i) * 4 * 1000 + 56);
            check($sformatf("walk%0d_lat", i), last_k, 35);
        end
        run_op(1'b0, 1'b0, 0, 200);
        check("wall_plots", n_plot, 0);
        check("wall_end", end_k, 1);
        check("wall_go", 32'(m_go), 1);

        // MAX_LEN=4 build.
        reset_a = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        check("b_rst_len", 32'(m_len), 0);
        run_op(1'b1, 1'b0, 0, 200);
        check("b_init", n_grn, 48);
        check("b_init_len", 32'(m_len), 3);
        food_x = 6'd21; food_y = 6'd15;
        run_op(1'b0, 1'b0, 0, 200);
        check("b_grow_food", n_food, 1);
        check("b_grow_blk", n_blk, 0);
        check("b_grow_len", 32'(m_len), 4);
        check("b_grow_fg_x", fg_x, 84);
        food_x = 6'd22; food_y = 6'd15;
        run_op(1'b0, 1'b0, 0, 200);
        food_x = 6'd39; food_y = 6'd29;
        check("b_full_food", n_food, 1);
        check("b_full_blk", n_blk, 16);
        check("b_full_fb_x", fb_x, 72);
        check("b_full_fg_x", fg_x, 88);
        check("b_full_len", 32'(m_len), 4);
        check("b_full_lat", last_k, 36);
        for (int j = 1; j <= 10; j++) begin
            run_op(1'b0, 1'b0, 0, 200);
            check($sformatf("wrap%0d_fb_x", j), fb_x, 4 * (18 + j));
            check($sformatf("wrap%0d_fg_x", j), fg_x, 4 * (22 + j));
            check($sformatf("wrap%0d_len", j), 32'(m_len), 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
